logic_unit_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 16-bit bitwise logic unit (NOT/AND/OR/XOR) between NUM_REQ requesters in the accelerator datapath. It accepts one operation per cycle via valid/ready handshakes and computes the result through the shared unit. The result is held in a single output register, with backpressure, tagged with the requester ID. It also keeps a completed-operation counter for debug and performance readout.

---
 rtl/logic_unit_arbiter.sv | 155 +++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
// Round-robin arbiter sharing one 16-bit bitwise logic unit (NOT/AND/OR/XOR)
// between NUM_REQ requesters. It accepts one operation per cycle and holds
// the result in a single output register with backpressure. The result is
// tagged with the owning requester. A drain counter is kept for debug.
//
// Ports:
//   clk, reset         rising-edge clock, async active-high reset
//   req_valid/ready    per-requester handshake (ready is combinational, one-hot or zero)
//   req_op/a/b         packed per-requester opcode and operands
//   resp_valid/ready   output register handshake
//   resp_data/resp_id  registered result and owning requester index
//   ops_done           count of drained results, wraps at 16 bits
module logic_unit_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned DATA_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [2*NUM_REQ-1:0]      req_op,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_W-1:0]         resp_data,
  output logic [ID_W-1:0]           resp_id,
  output logic [15:0]               ops_done
);

  localparam int unsigned SW = ID_W + 1;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam logic [1:0] OP_NOT = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  logic [0:0]            state, state_next;
  logic [ID_W-1:0]       last_grant;
  logic [SW-1:0]         start;
  logic [2*NUM_REQ-1:0]  valid_dbl;
  logic [2*NUM_REQ-1:0]  valid_shift;
  logic [NUM_REQ-1:0]    valid_rot;
  int unsigned           rot_off;
  logic                  grant_any;
  logic [ID_W-1:0]       grant_idx;
  logic                  can_accept;
  logic                  accept;
  logic                  drain;
  logic [1:0]            sel_op;
  logic [DATA_W-1:0]     sel_a, sel_b;
  logic [DATA_W-1:0]     alu_res;

  assign resp_valid = state[0];
  assign can_accept = !resp_valid || resp_ready;
  assign drain      = resp_valid && resp_ready;
  assign accept     = |(req_valid & req_ready);

  // Search begins one past the last grant; rotate so that position is bit 0.
  always_comb begin
    start = {1'b0, last_grant} + SW'(1);
    if (start >= SW'(NUM_REQ)) start = '0;
  end

  assign valid_dbl   = {req_valid, req_valid};
  assign valid_shift = valid_dbl >> start;
  assign valid_rot   = valid_shift[NUM_REQ-1:0];

  // Priority encode the rotated vector; lowest offset wins.
  always_comb begin
    grant_any = 1'b0;
    rot_off   = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (valid_rot[j]) begin
        grant_any = 1'b1;
        rot_off   = 32'(j);
      end
    end
    grant_idx = ID_W'((32'(start) + rot_off) % NUM_REQ);
  end

  // One-hot ready to the winner, forced low while in reset.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = !reset && can_accept && grant_any && (grant_idx == ID_W'(i));
    end
  end

  // Operand mux from the granted requester.
  always_comb begin
    sel_op = OP_NOT;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_op = req_op[2*i +: 2];
        sel_a  = req_a[DATA_W*i +: DATA_W];
        sel_b  = req_b[DATA_W*i +: DATA_W];
      end
    end
  end

  // Shared bitwise logic unit.
  always_comb begin
    alu_res = '0;
    case (sel_op)
      OP_NOT:  alu_res = ~sel_a;
      OP_AND:  alu_res = sel_a & sel_b;
      OP_OR:   alu_res = sel_a | sel_b;
      OP_XOR:  alu_res = sel_a ^ sel_b;
      default: alu_res = '0;
    endcase
  end

  // Output register occupancy: EMPTY/FULL mirrors resp_valid.
  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: if (accept) state_next = ST_FULL;
      ST_FULL:  if (drain && !accept) state_next = ST_EMPTY;
      default:  state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_next;
  end

  // Result register, owner tag and round-robin pointer load only on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_data  <= '0;
      resp_id    <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else if (accept) begin
      resp_data  <= alu_res;
      resp_id    <= grant_idx;
      last_grant <= grant_idx;
    end
  end

  // Drain counter, naturally wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      ops_done <= '0;
    else if (drain) ops_done <= ops_done + 16'd1;
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed testbench for logic_unit_arbiter (NUM_REQ=4).
module tb_logic_unit_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic [1:0]  resp_id;
  logic [15:0] ops_done;

  int tests;
  int fails;

  logic [1:0]  exp_g [5];
  logic [15:0] exp_d [4];

  logic_unit_arbiter #(.NUM_REQ(4), .ID_W(2), .DATA_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .ops_done   (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b);
    req_op[2*i +: 2]  = op;
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    req_valid = 4'hF;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    resp_ready = 1'b0;

    // Reset state, ready suppressed even with all requesters valid
    #2;
    chk("rst_valid", 16'(resp_valid), 16'h0);
    chk("rst_data", resp_data, 16'h0);
    chk("rst_id", 16'(resp_id), 16'h0);
    chk("rst_ops", ops_done, 16'h0);
    chk("rst_ready", 16'(req_ready), 16'h0);
    req_valid = 4'h0;
    tick();
    tick();
    reset = 1'b0;

    // Single NOT from requester 0
    set_req(0, 2'b00, 16'h0110, 16'h0000);
    req_valid = 4'b0001;
    resp_ready = 1'b1;
    #1;
    chk("not_ready", 16'(req_ready), 16'h0001);
    tick();
    req_valid = 4'b0000;
    chk("not_valid", 16'(resp_valid), 16'h1);
    chk("not_data", resp_data, 16'hFEEF);
    chk("not_id", 16'(resp_id), 16'h0);
    chk("not_ops_pre", ops_done, 16'h0);
    tick();
    chk("not_drained", 16'(resp_valid), 16'h0);
    chk("not_ops", ops_done, 16'h1);

    // All four valid; last grant was 0 so rotation starts at 1
    set_req(0, 2'b10, 16'h00F0, 16'h0F00);
    set_req(1, 2'b00, 16'hFFFF, 16'h1234);
    set_req(2, 2'b01, 16'h9C48, 16'h1A27);
    set_req(3, 2'b11, 16'h0491, 16'h00B7);
    exp_d[0] = 16'h0FF0;
    exp_d[1] = 16'h0000;
    exp_d[2] = 16'h1800;
    exp_d[3] = 16'h0426;
    exp_g[0] = 2'd1; exp_g[1] = 2'd2; exp_g[2] = 2'd3; exp_g[3] = 2'd0; exp_g[4] = 2'd1;
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_ready", 16'(req_ready), 16'(4'b0001 << exp_g[k]));
      tick();
      chk("rr_valid", 16'(resp_valid), 16'h1);
      chk("rr_id", 16'(resp_id), 16'(exp_g[k]));
      chk("rr_data", resp_data, exp_d[exp_g[k]]);
    end
    chk("rr_ops", ops_done, 16'd5);
    req_valid = 4'h0;
    tick();
    chk("rr_drain", 16'(resp_valid), 16'h0);
    chk("rr_ops2", ops_done, 16'd6);

    // Backpressure: accept from requester 0, then stall with requester 1 waiting
    set_req(0, 2'b11, 16'h1234, 16'h00FF);
    set_req(1, 2'b01, 16'hF0F0, 16'hFF00);
    req_valid = 4'b0001;
    resp_ready = 1'b0;
    #1;
    chk("bp_ready0", 16'(req_ready), 16'h0001);
    tick();
    chk("bp_data0", resp_data, 16'h12CB);
    req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_ready_stall", 16'(req_ready), 16'h0);
      tick();
      chk("bp_valid_stall", 16'(resp_valid), 16'h1);
      chk("bp_data_stall", resp_data, 16'h12CB);
      chk("bp_id_stall", 16'(resp_id), 16'h0);
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_ready_go", 16'(req_ready), 16'h0002);
    tick();
    req_valid = 4'h0;
    chk("bp_valid_go", 16'(resp_valid), 16'h1);
    chk("bp_data_go", resp_data, 16'hF000);
    chk("bp_id_go", 16'(resp_id), 16'h1);
    chk("bp_ops", ops_done, 16'd7);
    tick();
    chk("bp_ops2", ops_done, 16'd8);

    // Priority retention across idle cycles
    req_valid = 4'b0100;
    tick();
    chk("pr_id2", 16'(resp_id), 16'h2);
    req_valid = 4'b0000;
    tick();
    tick();
    tick();
    req_valid = 4'b1001;
    #1;
    chk("pr_ready3", 16'(req_ready), 16'h0008);
    tick();
    chk("pr_id3", 16'(resp_id), 16'h3);
    chk("pr_data3", resp_data, 16'h0426);
    chk("pr_ready0", 16'(req_ready), 16'h0001);
    tick();
    req_valid = 4'b0000;
    chk("pr_id0", 16'(resp_id), 16'h0);
    chk("pr_data0", resp_data, 16'h12CB);
    tick();
    chk("pr_ops", ops_done, 16'd11);

    // Reset while holding a stalled result
    resp_ready = 1'b0;
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0000;
    chk("mr_valid_pre", 16'(resp_valid), 16'h1);
    chk("mr_id_pre", 16'(resp_id), 16'h1);
    #2;
    reset = 1'b1;
    req_valid = 4'b0011;
    #1;
    chk("mr_valid", 16'(resp_valid), 16'h0);
    chk("mr_data", resp_data, 16'h0);
    chk("mr_id", 16'(resp_id), 16'h0);
    chk("mr_ops", ops_done, 16'h0);
    chk("mr_ready", 16'(req_ready), 16'h0);
    tick();
    reset = 1'b0;
    resp_ready = 1'b1;
    #1;
    chk("mr_ready_post", 16'(req_ready), 16'h0001);
    tick();
    chk("mr_id_post", 16'(resp_id), 16'h0);
    chk("mr_ready_next", 16'(req_ready), 16'h0002);
    req_valid = 4'b0000;

    // Counter wrap after a clean reset
    #1;
    reset = 1'b1;
    #1;
    tick();
    reset = 1'b0;
    req_valid = 4'b0001;
    resp_ready = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    req_valid = 4'b0000;
    tick();
    chk("wrap_max", ops_done, 16'hFFFF);
    chk("wrap_empty", 16'(resp_valid), 16'h0);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    tick();
    chk("wrap_zero", ops_done, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
